// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the control unit and alu_seq.
// The master side (control unit) issues requests; the slave side (ALU) returns
// the registered result and the start/busy/done handshake status.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [15:0]      instruction;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] read_data;
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] Z;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, instruction, X, Y, read_data, PC,
      input  Z, busy, done, div_by_zero
   );

   modport slave (
      input  start, instruction, X, Y, read_data, PC,
      output Z, busy, done, div_by_zero
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a registered result.
// Single-cycle ops complete one edge after start. Opcode 1011 runs an
// iterative shift-add multiplier (and, when ALU_SEQ_DIVIDE_EN is defined, a
// restoring divider) for WIDTH steps while busy is high.
// Build option: `define ALU_SEQ_DIVIDE_EN to include the DIV/REM datapath;
// without it DIV/REM complete in one cycle with Z=0.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic     clock,
   input  logic     reset,
   alu_seq_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic [3:0] opcode;
   logic [3:0] func;
   logic [7:0] imm8;

   assign opcode = bus.instruction[15:12];
   assign imm8   = bus.instruction[11:4];
   assign func   = bus.instruction[3:0];

   state_t               state_q, state_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   // Shared shift register: {acc, multiplier} for MUL, {remainder, quotient} for DIV.
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH-1:0]     x_q, x_d;
   logic                 hi_q, hi_d;
   logic [WIDTH-1:0]     z_q, z_d;
   logic                 done_q, done_d;
   logic                 dbz_q, dbz_d;
`ifdef ALU_SEQ_DIVIDE_EN
   logic [WIDTH-1:0]     y_q, y_d;
   logic                 div_q, div_d;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
`endif

   logic                 is_iter;
   logic [WIDTH-1:0]     sc_res;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   step;

   // Decide whether the presented request needs the iterative datapath.
   always_comb begin
      is_iter = 1'b0;
      if (opcode == 4'b1011) begin
         case (func)
            4'b0000, 4'b0001: is_iter = 1'b1;
`ifdef ALU_SEQ_DIVIDE_EN
            4'b0010, 4'b0011: is_iter = 1'b1;
`endif
            default:          is_iter = 1'b0;
         endcase
      end
   end

   // Single-cycle result; opcode 1011 and any non-iterative func give zero.
   always_comb begin
      sc_res = '0;
      case (opcode)
         4'b0000: sc_res = bus.X + bus.Y;
         4'b0001: sc_res = bus.X - bus.Y;
         4'b0010: sc_res = bus.X & bus.Y;
         4'b0011: sc_res = bus.X | bus.Y;
         4'b0100: sc_res = bus.X ^ bus.Y;
         4'b0101: sc_res = bus.X >> bus.Y[SHW-1:0];
         4'b0110: sc_res = bus.X << bus.Y[SHW-1:0];
         4'b0111: sc_res = WIDTH'(bus.X >= bus.Y);
         4'b1000: sc_res = bus.PC + WIDTH'(1);
         4'b1001: sc_res = WIDTH'(bus.Y == '0);
         4'b1010: sc_res = WIDTH'(bus.Y != '0);
         4'b1100: sc_res = bus.read_data;
         4'b1101: sc_res = bus.Y;
         4'b1110: begin
            sc_res       = bus.X;
            sc_res[7:0]  = imm8;
         end
         4'b1111: begin
            sc_res       = bus.X;
            sc_res[15:8] = imm8;
         end
         default: sc_res = '0;
      endcase
   end

   // One iteration: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, x_q} : '0);
      step    = {mul_sum, prod_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIVIDE_EN
      div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, y_q};
      if (div_q) begin
         // A zero divisor always "fits", giving all-ones quotient and remainder X.
         if (div_shift >= {1'b0, y_q}) begin
            step = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
         end else begin
            step = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // Next-state and datapath updates for the IDLE/RUN controller.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      x_d     = x_q;
      hi_d    = hi_q;
      z_d     = z_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
`ifdef ALU_SEQ_DIVIDE_EN
      y_d     = y_q;
      div_d   = div_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (is_iter) begin
                  x_d     = bus.X;
                  hi_d    = func[0];
                  prod_d  = {{WIDTH{1'b0}}, bus.Y};
`ifdef ALU_SEQ_DIVIDE_EN
                  y_d     = bus.Y;
                  div_d   = func[1];
                  if (func[1]) begin
                     prod_d = {{WIDTH{1'b0}}, bus.X};
                  end
`endif
                  cnt_d   = SHW'(WIDTH - 1);
                  state_d = RUN;
               end else begin
                  z_d    = sc_res;
                  done_d = 1'b1;
                  dbz_d  = 1'b0;
               end
            end
         end
         RUN: begin
            prod_d = step;
            if (cnt_q == '0) begin
               // High half is MULH / REM, low half is MULL / DIV.
               z_d     = hi_q ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
               done_d  = 1'b1;
               dbz_d   = 1'b0;
`ifdef ALU_SEQ_DIVIDE_EN
               dbz_d   = div_q && (y_q == '0);
`endif
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - SHW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset aborts any run in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         x_q     <= '0;
         hi_q    <= 1'b0;
         z_q     <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
`ifdef ALU_SEQ_DIVIDE_EN
         y_q     <= '0;
         div_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         x_q     <= x_d;
         hi_q    <= hi_d;
         z_q     <= z_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
`ifdef ALU_SEQ_DIVIDE_EN
         y_q     <= y_d;
         div_q   <= div_d;
`endif
      end
   end

   assign bus.Z           = z_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.busy        = (state_q == RUN);

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the NBBPU single-cycle ALU. It keeps the 4-bit opcode map and adds iterative multiply and divide under the previously reserved opcode `4'b1011`. A start/busy/done handshake lets the control unit stall while an iterative operation runs. The output is registered. The block sits between the register file and the write-back mux.

## Interface
Parameters:
- `WIDTH`, 16, datapath width. Legal values are 16 and 32.
- `SHW`, `$clog2(WIDTH)`, shift-amount width. Derived; do not override.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `instruction`  in  16  `[15:12]` opcode, `[11:4]` imm8, `[3:0]` func (opcode 1011 only).
- `X`, `Y`  in  WIDTH  operands.
- `read_data`  in  WIDTH  memory load data.
- `PC`  in  WIDTH  program counter.
- `Z`  out  WIDTH  registered result; holds until the next completion.
- `busy`  out  1  high while an iterative operation runs.
- `done`  out  1  one-cycle pulse when `Z` is updated.
- `div_by_zero`  out  1  registered with `done`; set only by DIV/REM with Y=0.

## Operation
Single-cycle opcodes:
- 0000 add
- 0001 sub
- 0010 and
- 0011 or
- 0100 xor
- 0101 logical shift right by `Y[SHW-1:0]`
- 0110 logical shift left by `Y[SHW-1:0]`
- 0111 unsigned X>=Y ? 1 : 0
- 1000 PC+1
- 1001 Y==0 ? 1 : 0
- 1010 Y!=0 ? 1 : 0
- 1100 read_data
- 1101 Y
- 1110 `{X[WIDTH-1:8], imm8}`
- 1111 `{X[WIDTH-1:16], imm8, X[7:0]}` (the `X[WIDTH-1:16]` field is empty when WIDTH=16)

Results are computed modulo 2^WIDTH.

Opcode 1011 selects on func:
- 0000 MULL: low WIDTH bits of unsigned X*Y.
- 0001 MULH: high WIDTH bits of unsigned X*Y.
- 0010 DIV: unsigned X/Y.
- 0011 REM: unsigned X%Y.
- All other func values are single-cycle and give Z=0.

State machine, IDLE/RUN:
- IDLE, `start`, single-cycle op: Z←result, done←1, div_by_zero←0. Stay in IDLE. Back-to-back single-cycle ops are accepted every cycle.
- IDLE, `start`, iterative op: capture X, Y and func; counter←WIDTH-1; go to RUN.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. When counter==0: Z←result, done←1, go to IDLE. Otherwise decrement the counter.
- `busy` = (state==RUN), decoded combinationally from state.
- `start` is ignored in RUN. Operand changes after capture are ignored.
- Divide with Y=0 runs the full WIDTH cycles and gives DIV=all ones, REM=X, div_by_zero=1.

## Timing
- Reset values: Z=0, done=0, busy=0, div_by_zero=0, state=IDLE, counter=0.
- Single-cycle latency: `start` sampled at edge k gives Z/done valid after edge k.
- Iterative latency: `start` at edge k gives busy high after edge k. Z/done are valid and busy is low after edge k+WIDTH.
- The earliest next `start` is accepted at edge k+WIDTH+1. A `start` at edge k+WIDTH is seen while busy=1 and is dropped.
- `done` is high for exactly one cycle per accepted request. It is low in all other cycles.
- Reset asserted mid-RUN: the operation is aborted immediately, with no `done` and Z=0. A new `start` after reset deassertion behaves normally.

## Configuration
- `ALU_SEQ_DIVIDE_EN` defined: DIV/REM are built as described.
- `ALU_SEQ_DIVIDE_EN` undefined: the divider datapath is removed. DIV/REM become single-cycle, with Z=0, done after 1 cycle and div_by_zero=0. MULL/MULH are unchanged.

## Test plan
- Reset: hold `reset`=0 with random inputs → Z=0, done=0, busy=0, div_by_zero=0 throughout.
- Single-cycle ops, WIDTH=16:
  - ADD X=0xFFFF, Y=0x0002 → next cycle Z=0x0001, done=1.
  - Immediately followed by SUB X=0x0005, Y=0x0007 → next cycle Z=0xFFFE, done=1.
  - busy stays 0 throughout.
- Byte-set ops, X=0xABCD:
  - instruction=0xE5A0 → Z=0xAB5A.
  - instruction=0xF5A0 → Z=0x5ACD.
- Multiply, X=0x1234, Y=0x0100:
  - MULL (0xB000) → busy for 16 cycles, then Z=0x3400 with a single done pulse.
  - MULH (0xB001) → Z=0x0012.
  - A `start` pulsed at cycle 5 of the run is ignored.
- Divide (macro defined):
  - X=1000, Y=7: DIV → Z=142; REM → Z=6; 16-cycle latency.
  - DIV with Y=0 → Z=0xFFFF, div_by_zero=1.
  - Without the macro, DIV → Z=0 after 1 cycle.
- Reset mid-MUL at cycle 5 → busy=0 and Z=0 immediately, with no done pulse. A following ADD 2+3 → Z=5.
